// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns a PS/2 set-2 scancode byte stream into compact game
// key make/break events. Events are queued in a small show-ahead FIFO with a
// valid/ready handshake.
// Optional build macro: KEY_REPEAT_FILTER_EN (drops typematic repeat makes).
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_err,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_key,
  output logic       evt_break,
  output logic       overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  typedef struct packed {
    logic       brk;
    logic [4:0] key;
  } evt_t;

  // Returns {hit, key_id}. Only the arrow keys live in the extended space; the
  // same codes without E0 are keypad keys and stay unmapped.
  function automatic logic [5:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [5:0] r;
    r = '0;
    if (ext) begin
      case (code)
        8'h75:   r = {1'b1, 5'd20};
        8'h72:   r = {1'b1, 5'd21};
        8'h6B:   r = {1'b1, 5'd22};
        8'h74:   r = {1'b1, 5'd23};
        default: r = '0;
      endcase
    end else begin
      case (code)
        8'h45:   r = {1'b1, 5'd0};
        8'h16:   r = {1'b1, 5'd1};
        8'h1E:   r = {1'b1, 5'd2};
        8'h26:   r = {1'b1, 5'd3};
        8'h25:   r = {1'b1, 5'd4};
        8'h2E:   r = {1'b1, 5'd5};
        8'h36:   r = {1'b1, 5'd6};
        8'h3D:   r = {1'b1, 5'd7};
        8'h3E:   r = {1'b1, 5'd8};
        8'h46:   r = {1'b1, 5'd9};
        8'h1C:   r = {1'b1, 5'd10};
        8'h32:   r = {1'b1, 5'd11};
        8'h21:   r = {1'b1, 5'd12};
        8'h23:   r = {1'b1, 5'd13};
        8'h24:   r = {1'b1, 5'd14};
        8'h2B:   r = {1'b1, 5'd15};
        8'h34:   r = {1'b1, 5'd16};
        8'h33:   r = {1'b1, 5'd17};
        8'h43:   r = {1'b1, 5'd18};
        8'h3B:   r = {1'b1, 5'd19};
        8'h5A:   r = {1'b1, 5'd24};
        8'h76:   r = {1'b1, 5'd25};
        8'h66:   r = {1'b1, 5'd26};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  state_t     state, state_n;
  logic [2:0] skip_cnt, skip_n;
  logic       dec_en, dec_ext, dec_brk;
  logic [5:0] lookup;
  logic       hit, push, pop, wr_en, full, empty;
  evt_t       new_evt, head;

  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  // Prefix state and pause-skip counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_n;
      skip_cnt <= skip_n;
    end
  end

  // Prefix decoding: next state and the decode strobe for a completed code.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_n = state;
    skip_n  = skip_cnt;
    dec_en  = 1'b0;
    dec_ext = 1'b0;
    dec_brk = 1'b0;
    if (byte_err) begin
      state_n = S_IDLE;
      skip_n  = '0;
    end else if (byte_valid) begin
      case (state)
        S_IDLE: begin
          case (byte_in)
            8'hE0: state_n = S_EXT;
            8'hF0: state_n = S_BRK;
            8'hE1: begin
              state_n = S_SKIP;
              skip_n  = 3'd7;
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_n = S_IDLE;
            default: dec_en = 1'b1;
          endcase
        end
        S_EXT: begin
          case (byte_in)
            8'hF0:        state_n = S_EXT_BRK;
            8'hE0, 8'hE1: state_n = S_IDLE;
            default: begin
              dec_en  = 1'b1;
              dec_ext = 1'b1;
              state_n = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          dec_en  = 1'b1;
          dec_brk = 1'b1;
          state_n = S_IDLE;
        end
        S_EXT_BRK: begin
          dec_en  = 1'b1;
          dec_ext = 1'b1;
          dec_brk = 1'b1;
          state_n = S_IDLE;
        end
        S_SKIP: begin
          if (skip_cnt <= 3'd1) begin
            skip_n  = '0;
            state_n = S_IDLE;
          end else begin
            skip_n = skip_cnt - 3'd1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign lookup  = key_lookup(dec_ext, byte_in);
  assign hit     = dec_en & lookup[5];
  assign new_evt = '{brk: dec_brk, key: lookup[4:0]};

`ifdef KEY_REPEAT_FILTER_EN
  logic [26:0] held;

  assign push = hit & (dec_brk | ~held[new_evt.key]);

  // Held-key map: set on make, cleared on the matching break.
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
    end else if (hit) begin
      held[new_evt.key] <= ~dec_brk;
    end
  end
`else
  assign push = hit;
`endif

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop   = evt_valid & evt_ready;
  assign wr_en = push & (~full | pop);

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are live, and empty-state outputs are forced to zero.
    if (wr_en) mem[wr_ptr] <= new_evt;
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = ~empty;
  assign evt_key   = evt_valid ? head.key : 5'd0;
  assign evt_break = evt_valid ? head.brk : 1'b0;

endmodule
